// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command sequencer.
// The checksum helper is only used when UART_CMD_CHKSUM_EN is defined.
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    CHK,
    DONE
  } state_t;

  function automatic logic [BYTE_W-1:0] chksum8(input logic [BYTE_W-1:0] acc,
                                                input logic [BYTE_W-1:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_cmd_tmr.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYC-1 is reached; saturates there instead of wrapping.
module uart_cmd_tmr #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: opcode + NUM_DATA_BYTES payload, cmd_rdy handshake, inter-byte timeout.
// Define UART_CMD_CHKSUM_EN to require a trailing mod-256 checksum byte.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_DATA_BYTES = 2,
  parameter int unsigned TIMEOUT_CYC    = 50000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rx_rdy,
  input  logic [BYTE_W-1:0]                rx_data,
  output logic                             rx_rdy_clr,
  input  logic                             clr_cmd_rdy,
  output logic [BYTE_W-1:0]                cmd,
  output logic [BYTE_W*NUM_DATA_BYTES-1:0] data,
  output logic                             cmd_rdy,
  output logic                             cmd_err
);

  localparam int unsigned DATA_W = BYTE_W * NUM_DATA_BYTES;
  localparam int unsigned IDX_W  = (NUM_DATA_BYTES > 1) ? $clog2(NUM_DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DATA_BYTES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              cmd_err_q, cmd_err_d;
  logic              tmr_en;
  logic              tmr_expired;

  // The timer only runs while a command is partially assembled.
  assign tmr_en = (state_q == CAPT) || (state_q == CHK);

  uart_cmd_tmr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_rdy_clr || !tmr_en),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

`ifdef UART_CMD_CHKSUM_EN
  logic [BYTE_W-1:0] sum;

  always_comb begin
    sum = cmd_q;
    for (int i = 0; i < int'(NUM_DATA_BYTES); i++) begin
      sum = chksum8(sum, data_q[BYTE_W*i +: BYTE_W]);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    cmd_rdy_d  = cmd_rdy_q;
    cmd_err_d  = 1'b0;
    // DONE is excluded so the receiver is stalled while a command is unread.
    rx_rdy_clr = rx_rdy && ((state_q == IDLE) || (state_q == CAPT) || (state_q == CHK));

    unique case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          cmd_d   = rx_data;
          idx_d   = '0;
          state_d = CAPT;
        end
      end
      CAPT: begin
        if (rx_rdy) begin
          data_d[BYTE_W*(NUM_DATA_BYTES - 1 - 32'(idx_q)) +: BYTE_W] = rx_data;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef UART_CMD_CHKSUM_EN
            state_d = CHK;
`else
            state_d   = DONE;
            cmd_rdy_d = 1'b1;
`endif
          end
        end else if (tmr_expired) begin
          cmd_err_d = 1'b1;
          idx_d     = '0;
          state_d   = IDLE;
        end
      end
`ifdef UART_CMD_CHKSUM_EN
      CHK: begin
        if (rx_rdy) begin
          if (rx_data == sum) begin
            state_d   = DONE;
            cmd_rdy_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (tmr_expired) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
`endif
      DONE: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign cmd     = cmd_q;
  assign data    = data_q;
  assign cmd_rdy = cmd_rdy_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: dut0 uses the default timeout, dut1 a 4-cycle timeout.
// Honours UART_CMD_CHKSUM_EN when defined.
module tb_uart_cmd_ctrl;

  localparam int unsigned N       = 2;
  localparam int unsigned T_SMALL = 4;
`ifdef UART_CMD_CHKSUM_EN
  localparam int unsigned NB = N + 2;
`else
  localparam int unsigned NB = N + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy      [2];
  logic [7:0]  rx_data     [2];
  logic        rx_rdy_clr  [2];
  logic        clr_cmd_rdy [2];
  logic [7:0]  cmd         [2];
  logic [15:0] data        [2];
  logic        cmd_rdy     [2];
  logic        cmd_err     [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int clr_cnt   [2] = '{0, 0};
  int err_cnt   [2] = '{0, 0};
  int err_cyc   [2] = '{0, 0};
  int last_cons [2] = '{0, 0};

  uart_cmd_ctrl #(
    .NUM_DATA_BYTES(N)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy[0]),
    .rx_data    (rx_data[0]),
    .rx_rdy_clr (rx_rdy_clr[0]),
    .clr_cmd_rdy(clr_cmd_rdy[0]),
    .cmd        (cmd[0]),
    .data       (data[0]),
    .cmd_rdy    (cmd_rdy[0]),
    .cmd_err    (cmd_err[0])
  );

  uart_cmd_ctrl #(
    .NUM_DATA_BYTES(N),
    .TIMEOUT_CYC   (T_SMALL)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy[1]),
    .rx_data    (rx_data[1]),
    .rx_rdy_clr (rx_rdy_clr[1]),
    .clr_cmd_rdy(clr_cmd_rdy[1]),
    .cmd        (cmd[1]),
    .data       (data[1]),
    .cmd_rdy    (cmd_rdy[1]),
    .cmd_err    (cmd_err[1])
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent posedge; monitors see pre-edge values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rx_rdy_clr[i]) clr_cnt[i] <= clr_cnt[i] + 1;
      if (cmd_err[i]) begin
        err_cnt[i] <= err_cnt[i] + 1;
        err_cyc[i] <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receiver model: byte valid `gap` cycles after the previous consume edge + 1, held until taken.
  task automatic send(input int i, input logic [7:0] b, input int gap);
    int w;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    rx_rdy[i]  = 1'b1;
    rx_data[i] = b;
    w = 0;
    #1;
    while (!rx_rdy_clr[i] && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("consume", 32'(rx_rdy_clr[i]), 32'd1);
    @(posedge clk);
    #1;
    rx_rdy[i]    = 1'b0;
    last_cons[i] = cyc;
  endtask

  task automatic cmd_ok(input int i, input logic [7:0] op, input logic [7:0] d1,
                        input logic [7:0] d2, input int gap, input string tag);
    logic [7:0] s;
    s = op + d1 + d2;
    send(i, op, 0);
    send(i, d1, gap);
    send(i, d2, gap);
`ifdef UART_CMD_CHKSUM_EN
    send(i, s, 0);
`endif
    check({tag, "_rdy"}, 32'(cmd_rdy[i]), 32'd1);
    check({tag, "_cmd"}, 32'(cmd[i]), 32'(op));
    check({tag, "_data"}, 32'(data[i]), 32'({d1, d2}));
  endtask

  task automatic clear(input int i, input string tag);
    @(negedge clk);
    clr_cmd_rdy[i] = 1'b1;
    @(negedge clk);
    clr_cmd_rdy[i] = 1'b0;
    #1;
    check({tag, "_clr"}, 32'(cmd_rdy[i]), 32'd0);
  endtask

  initial begin
    int c0;
    int prev;
    int exp_err0;
    int exp_err1;
    int p;
    int gap;
    logic [7:0] b;
    logic [7:0] got [4];

    exp_err0 = 0;
    exp_err1 = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_rdy[i]      = 1'b0;
      rx_data[i]     = 8'h00;
      clr_cmd_rdy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_cmd", 32'(cmd[i]), 32'd0);
      check("rst_data", 32'(data[i]), 32'd0);
      check("rst_rdy", 32'(cmd_rdy[i]), 32'd0);
      check("rst_err", 32'(cmd_err[i]), 32'd0);
      check("rst_clr", 32'(rx_rdy_clr[i]), 32'd0);
    end
    rst_n = 1'b1;

    // T1: slow bytes, well inside the default timeout.
    c0 = clr_cnt[0];
    cmd_ok(0, 8'hA5, 8'h12, 8'h34, 99, "t1");
    check("t1_strobes", clr_cnt[0] - c0, NB);
    check("t1_no_err", err_cnt[0], exp_err0);
    clear(0, "t1");
    check("t1_hold_cmd", 32'(cmd[0]), 32'hA5);

    // T2: timeout after a partial command, then a clean command.
    send(1, 8'hA5, 0);
    send(1, 8'h12, 0);
    prev = last_cons[1];
    repeat (T_SMALL + 3) @(negedge clk);
    exp_err1++;
    check("t2_err_cnt", err_cnt[1], exp_err1);
    check("t2_err_cyc", err_cyc[1], prev + T_SMALL);
    check("t2_rdy", 32'(cmd_rdy[1]), 32'd0);
    repeat (4) @(negedge clk);
    check("t2_single", err_cnt[1], exp_err1);
    cmd_ok(1, 8'h01, 8'h02, 8'h03, 0, "t2");
    clear(1, "t2");

    // T3: byte arriving on the last timer cycle wins; one cycle later loses.
    send(1, 8'hA5, 0);
    send(1, 8'h12, 0);
    send(1, 8'h34, T_SMALL - 1);
`ifdef UART_CMD_CHKSUM_EN
    send(1, 8'hEB, 0);
`endif
    check("t3_no_err", err_cnt[1], exp_err1);
    check("t3_rdy", 32'(cmd_rdy[1]), 32'd1);
    check("t3_data", 32'(data[1]), 32'h1234);
    clear(1, "t3");
    send(1, 8'hA5, 0);
    send(1, 8'h12, 0);
    prev = last_cons[1];
    send(1, 8'h34, T_SMALL);
    exp_err1++;
    check("t3_err_cnt", err_cnt[1], exp_err1);
    check("t3_err_cyc", err_cyc[1], prev + T_SMALL);
    check("t3_err_rdy", 32'(cmd_rdy[1]), 32'd0);
    check("t3_new_op", 32'(cmd[1]), 32'h34);
    send(1, 8'h56, 0);
    send(1, 8'h78, 0);
`ifdef UART_CMD_CHKSUM_EN
    send(1, 8'h02, 0);
`endif
    check("t3b_rdy", 32'(cmd_rdy[1]), 32'd1);
    check("t3b_data", 32'(data[1]), 32'h5678);
    clear(1, "t3b");

    // T4: backpressure while a command is unread.
    cmd_ok(0, 8'h11, 8'h22, 8'h33, 0, "t4a");
    @(negedge clk);
    rx_rdy[0]  = 1'b1;
    rx_data[0] = 8'h77;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_stall", 32'(rx_rdy_clr[0]), 32'd0);
      check("t4_cmd_hold", 32'(cmd[0]), 32'h11);
      check("t4_data_hold", 32'(data[0]), 32'h2233);
      @(negedge clk);
    end
    clr_cmd_rdy[0] = 1'b1;
    #1;
    check("t4_stall_clr", 32'(rx_rdy_clr[0]), 32'd0);
    @(posedge clk);
    #1;
    clr_cmd_rdy[0] = 1'b0;
    check("t4_rdy_low", 32'(cmd_rdy[0]), 32'd0);
    check("t4_take", 32'(rx_rdy_clr[0]), 32'd1);
    @(posedge clk);
    #1;
    rx_rdy[0]    = 1'b0;
    last_cons[0] = cyc;
    check("t4_op", 32'(cmd[0]), 32'h77);
    send(0, 8'h88, 0);
    send(0, 8'h99, 0);
`ifdef UART_CMD_CHKSUM_EN
    send(0, 8'h98, 0);
`endif
    check("t4_rdy", 32'(cmd_rdy[0]), 32'd1);
    check("t4_data", 32'(data[0]), 32'h8899);
    clear(0, "t4");

    // T5: asynchronous reset after the opcode only.
    send(0, 8'h5A, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_cmd", 32'(cmd[0]), 32'd0);
    check("t5_data", 32'(data[0]), 32'd0);
    check("t5_rdy", 32'(cmd_rdy[0]), 32'd0);
    check("t5_err", 32'(cmd_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ok(0, 8'hC3, 8'h4D, 8'h5E, 2, "t5");
    clear(0, "t5");

`ifdef UART_CMD_CHKSUM_EN
    // T6: checksum accept and reject.
    cmd_ok(0, 8'hA5, 8'h12, 8'h34, 0, "t6");
    clear(0, "t6");
    send(0, 8'hA5, 0);
    send(0, 8'h12, 0);
    send(0, 8'h34, 0);
    send(0, 8'h00, 0);
    prev = last_cons[0];
    @(posedge clk);
    #1;
    exp_err0++;
    check("t6_err_cnt", err_cnt[0], exp_err0);
    check("t6_err_cyc", err_cyc[0], prev);
    check("t6_rdy", 32'(cmd_rdy[0]), 32'd0);
`endif

    // Random stream on dut1: a byte gap longer than the timeout restarts assembly.
    p = 0;
    for (int k = 0; k < 60; k++) begin
      b    = 8'($urandom);
      gap  = (p == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
`ifdef UART_CMD_CHKSUM_EN
      if (p == int'(N) + 1) begin
        b   = got[0] + got[1] + got[2];
        gap = int'($urandom_range(0, 3));
      end
`endif
      prev = last_cons[1];
      send(1, b, gap);
      if (p > 0 && gap + 1 > int'(T_SMALL)) begin
        exp_err1++;
        check("rnd_err_cyc", err_cyc[1], prev + T_SMALL);
        p = 0;
      end
      check("rnd_err_cnt", err_cnt[1], exp_err1);
      got[p] = b;
      p++;
      if (p == 1) check("rnd_op", 32'(cmd[1]), 32'(b));
      if (p == int'(NB)) begin
        check("rnd_rdy", 32'(cmd_rdy[1]), 32'd1);
        check("rnd_cmd", 32'(cmd[1]), 32'(got[0]));
        check("rnd_data", 32'(data[1]), 32'({got[1], got[2]}));
        clear(1, "rnd");
        p = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
